// File: rtl/traffic_light_monitor_if.sv
// Light interface between traffic_light_controller (master) and traffic_light_monitor (slave).
// The master drives the lights and clear. The slave returns phase tracking and error status.
interface traffic_light_monitor_if;
    logic        red;
    logic        yellow;
    logic        green;
    logic        clear;
    logic [1:0]  phase;
    logic        locked;
    logic        err_onehot;
    logic        err_order;
    logic        err_timing;
    logic        fault;
    logic [15:0] rounds;

    modport master (
        output red, yellow, green, clear,
        input  phase, locked, err_onehot, err_order, err_timing, fault, rounds
    );

    modport slave (
        input  red, yellow, green, clear,
        output phase, locked, err_onehot, err_order, err_timing, fault, rounds
    );
endinterface

// File: rtl/traffic_light_monitor.sv
// Passive checker for red/yellow/green lights: one-hot, RED->GREEN->YELLOW->RED order, phase durations.
// Optional macro TLM_TOLERANCE_EN widens the accepted duration window to [EXP-TOL, EXP+TOL].
module traffic_light_monitor #(
    parameter int RED_CYCLES    = 4,
    parameter int GREEN_CYCLES  = 3,
    parameter int YELLOW_CYCLES = 2,
    parameter int CNT_W         = 8,
    parameter int TOL           = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    traffic_light_monitor_if.slave  mon_if
);

`ifdef TLM_TOLERANCE_EN
    localparam int TOL_EFF = TOL;
`else
    localparam int TOL_EFF = 0 * TOL;
`endif

    // Lower bound clamps at 1; the upper value is the first overrun count.
    localparam int RED_LO     = (RED_CYCLES - TOL_EFF < 1) ? 1 : RED_CYCLES - TOL_EFF;
    localparam int GREEN_LO   = (GREEN_CYCLES - TOL_EFF < 1) ? 1 : GREEN_CYCLES - TOL_EFF;
    localparam int YELLOW_LO  = (YELLOW_CYCLES - TOL_EFF < 1) ? 1 : YELLOW_CYCLES - TOL_EFF;
    localparam int RED_HI1    = RED_CYCLES + TOL_EFF + 1;
    localparam int GREEN_HI1  = GREEN_CYCLES + TOL_EFF + 1;
    localparam int YELLOW_HI1 = YELLOW_CYCLES + TOL_EFF + 1;

    typedef enum logic [1:0] {
        PH_NONE   = 2'd0,
        PH_RED    = 2'd1,
        PH_GREEN  = 2'd2,
        PH_YELLOW = 2'd3
    } phase_e;

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'd0,
        ST_PARTIAL = 2'd1,
        ST_CHECKED = 2'd2
    } state_e;

    state_e             st_q;
    phase_e             phase_q;
    logic               locked_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               overrun_q;
    logic               round_ok_q;
    logic               err_onehot_q;
    logic               err_order_q;
    logic               err_timing_q;
    logic               fault_q;
    logic [15:0]        rounds_q;

    logic               onehot;
    phase_e             samp_ph;
    phase_e             legal_next;
    logic               known;
    logic               same_ph;
    logic               legal_tr;
    logic               illegal_tr;
    logic               overrun_hit;
    logic               underrun_hit;
    logic [CNT_W-1:0]   cnt_inc;
    logic [CNT_W-1:0]   exp_lo;
    logic [CNT_W-1:0]   exp_hi1;
    logic               err_onehot_d;
    logic               err_order_d;
    logic               err_timing_d;
    logic               fault_d;

    always_comb begin
        onehot  = 1'b1;
        samp_ph = PH_NONE;
        case ({mon_if.red, mon_if.yellow, mon_if.green})
            3'b100:  samp_ph = PH_RED;
            3'b001:  samp_ph = PH_GREEN;
            3'b010:  samp_ph = PH_YELLOW;
            default: onehot  = 1'b0;
        endcase
    end

    always_comb begin
        legal_next = PH_NONE;
        exp_lo     = CNT_W'(RED_LO);
        exp_hi1    = CNT_W'(RED_HI1);
        case (phase_q)
            PH_RED: begin
                legal_next = PH_GREEN;
            end
            PH_GREEN: begin
                legal_next = PH_YELLOW;
                exp_lo     = CNT_W'(GREEN_LO);
                exp_hi1    = CNT_W'(GREEN_HI1);
            end
            PH_YELLOW: begin
                legal_next = PH_RED;
                exp_lo     = CNT_W'(YELLOW_LO);
                exp_hi1    = CNT_W'(YELLOW_HI1);
            end
            default: ;
        endcase
    end

    always_comb begin
        known        = (st_q != ST_UNKNOWN);
        same_ph      = onehot && known && (samp_ph == phase_q);
        legal_tr     = onehot && known && (samp_ph == legal_next);
        illegal_tr   = onehot && known && !same_ph && !legal_tr;
        cnt_inc      = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
        // Duration checks only apply once the phase was entered through a legal edge.
        overrun_hit  = same_ph && (st_q == ST_CHECKED) && !overrun_q && (cnt_inc == exp_hi1);
        underrun_hit = legal_tr && (st_q == ST_CHECKED) && !overrun_q && (cnt_q < exp_lo);
        err_onehot_d = !onehot;
        err_order_d  = illegal_tr;
        err_timing_d = overrun_hit || underrun_hit;
        fault_d      = fault_q;
        if (err_onehot_d || err_order_d || err_timing_d) begin
            fault_d = 1'b1;
        end else if (mon_if.clear) begin
            fault_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q         <= ST_UNKNOWN;
            phase_q      <= PH_NONE;
            locked_q     <= 1'b0;
            cnt_q        <= '0;
            overrun_q    <= 1'b0;
            round_ok_q   <= 1'b0;
            err_onehot_q <= 1'b0;
            err_order_q  <= 1'b0;
            err_timing_q <= 1'b0;
            fault_q      <= 1'b0;
            rounds_q     <= '0;
        end else begin
            err_onehot_q <= err_onehot_d;
            err_order_q  <= err_order_d;
            err_timing_q <= err_timing_d;
            fault_q      <= fault_d;
            if (!onehot) begin
                st_q       <= ST_UNKNOWN;
                phase_q    <= PH_NONE;
                locked_q   <= 1'b0;
                cnt_q      <= '0;
                overrun_q  <= 1'b0;
                round_ok_q <= 1'b0;
            end else if (!known) begin
                st_q       <= ST_PARTIAL;
                phase_q    <= samp_ph;
                cnt_q      <= CNT_W'(1);
                overrun_q  <= 1'b0;
                round_ok_q <= 1'b0;
            end else if (same_ph) begin
                cnt_q <= cnt_inc;
                if (overrun_hit) begin
                    overrun_q  <= 1'b1;
                    round_ok_q <= 1'b0;
                end
            end else if (legal_tr) begin
                st_q      <= ST_CHECKED;
                phase_q   <= samp_ph;
                locked_q  <= 1'b1;
                cnt_q     <= CNT_W'(1);
                overrun_q <= 1'b0;
                if ((st_q == ST_CHECKED) && (phase_q == PH_YELLOW) && round_ok_q && !underrun_hit) begin
                    rounds_q <= rounds_q + 16'd1;
                end
                // A legally entered red is always checked, so it opens a countable round.
                if (samp_ph == PH_RED) begin
                    round_ok_q <= 1'b1;
                end else begin
                    round_ok_q <= round_ok_q && !underrun_hit;
                end
            end else begin
                st_q       <= ST_PARTIAL;
                phase_q    <= samp_ph;
                locked_q   <= 1'b0;
                cnt_q      <= CNT_W'(1);
                overrun_q  <= 1'b0;
                round_ok_q <= 1'b0;
            end
        end
    end

    assign mon_if.phase      = phase_q;
    assign mon_if.locked     = locked_q;
    assign mon_if.err_onehot = err_onehot_q;
    assign mon_if.err_order  = err_order_q;
    assign mon_if.err_timing = err_timing_q;
    assign mon_if.fault      = fault_q;
    assign mon_if.rounds     = rounds_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed-vector bench for traffic_light_monitor: clean loops, timing/order/one-hot faults, async reset.
// Build with TLM_TOLERANCE_EN defined to exercise the tolerance window expectations.
module tb_traffic_light_monitor;

    localparam logic [2:0] R  = 3'b100;
    localparam logic [2:0] Y  = 3'b010;
    localparam logic [2:0] G  = 3'b001;
    localparam logic [2:0] RG = 3'b101;
    localparam logic [2:0] NONE = 3'b000;

`ifdef TLM_TOLERANCE_EN
    localparam int TOLB = 1;
`else
    localparam int TOLB = 0;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    int   step_no;
    logic exp_fault;

    traffic_light_monitor_if tl_if ();

    traffic_light_monitor #(
        .RED_CYCLES   (4),
        .GREEN_CYCLES (3),
        .YELLOW_CYCLES(2),
        .CNT_W        (8),
        .TOL          (1)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .mon_if(tl_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL step %0d %s got %0h expected %0h", step_no, tag, got, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        check({tag, "_phase"},  32'(tl_if.phase), 32'd0);
        check({tag, "_locked"}, 32'(tl_if.locked), 32'd0);
        check({tag, "_eoh"},    32'(tl_if.err_onehot), 32'd0);
        check({tag, "_eord"},   32'(tl_if.err_order), 32'd0);
        check({tag, "_etim"},   32'(tl_if.err_timing), 32'd0);
        check({tag, "_fault"},  32'(tl_if.fault), 32'd0);
        check({tag, "_rounds"}, 32'(tl_if.rounds), 32'd0);
    endtask

    task automatic step(input logic [2:0] ryg, input bit clr, input int ph, input bit lk,
                        input bit eo, input bit eord, input bit et, input int rnd);
        tl_if.red    = ryg[2];
        tl_if.yellow = ryg[1];
        tl_if.green  = ryg[0];
        tl_if.clear  = clr;
        @(posedge clk);
        #1;
        step_no++;
        if (eo || eord || et) exp_fault = 1'b1;
        else if (clr)         exp_fault = 1'b0;
        $display("step %0d ryg=%b clr=%b -> phase=%0d locked=%b eoh=%b eord=%b etim=%b fault=%b rounds=%0d",
                 step_no, ryg, clr, tl_if.phase, tl_if.locked, tl_if.err_onehot,
                 tl_if.err_order, tl_if.err_timing, tl_if.fault, tl_if.rounds);
        check("phase",  32'(tl_if.phase), 32'(ph));
        check("locked", 32'(tl_if.locked), 32'(lk));
        check("eoh",    32'(tl_if.err_onehot), 32'(eo));
        check("eord",   32'(tl_if.err_order), 32'(eord));
        check("etim",   32'(tl_if.err_timing), 32'(et));
        check("fault",  32'(tl_if.fault), 32'(exp_fault));
        check("rounds", 32'(tl_if.rounds), 32'(rnd));
        tl_if.clear = 1'b0;
    endtask

    // Hold one light for n samples; et_at/clr_at are 1-based sample indices (0 = none).
    task automatic run_phase(input logic [2:0] ryg, input int n, input int ph, input bit lk,
                             input int et_at, input int clr_at, input int rnd);
        for (int i = 1; i <= n; i++) begin
            step(ryg, (i == clr_at), ph, lk, 1'b0, 1'b0, (i == et_at), rnd);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        step_no   = 0;
        exp_fault = 1'b0;
        rst_n     = 1'b0;
        tl_if.red    = 1'b1;
        tl_if.yellow = 1'b0;
        tl_if.green  = 1'b0;
        tl_if.clear  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        rst_n = 1'b1;

        // Clean loop: first red partial, then three checked rounds of which two count.
        run_phase(R, 4, 1, 0, 0, 0, 0);
        run_phase(G, 3, 2, 1, 0, 0, 0);
        run_phase(Y, 2, 3, 1, 0, 0, 0);
        run_phase(R, 4, 1, 1, 0, 0, 0);
        run_phase(G, 3, 2, 1, 0, 0, 0);
        run_phase(Y, 2, 3, 1, 0, 0, 0);
        run_phase(R, 4, 1, 1, 0, 0, 1);
        run_phase(G, 3, 2, 1, 0, 0, 1);
        run_phase(Y, 2, 3, 1, 0, 0, 1);
        run_phase(R, 4, 1, 1, 0, 0, 2);

        // Green overrun: single pulse on sample 4, round not counted.
        run_phase(G, 5, 2, 1, 4, 0, 2);
        run_phase(Y, 2, 3, 1, 0, 0, 2);
        run_phase(R, 4, 1, 1, 0, 2, 2);

        // Yellow underrun flagged on the red sample, then clear.
        run_phase(G, 3, 2, 1, 0, 0, 2);
        run_phase(Y, 1, 3, 1, 0, 0, 2);
        run_phase(R, 4, 1, 1, 1, 3, 2);
        run_phase(G, 3, 2, 1, 0, 0, 2);
        run_phase(Y, 2, 3, 1, 0, 0, 2);
        run_phase(R, 4, 1, 1, 0, 0, 3);

        // Illegal RED->YELLOW, then legal recovery.
        step(Y, 1'b0, 3, 1'b0, 1'b0, 1'b1, 1'b0, 3);
        step(Y, 1'b0, 3, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        run_phase(R, 4, 1, 1, 0, 0, 3);
        run_phase(G, 3, 2, 1, 0, 0, 3);
        run_phase(Y, 2, 3, 1, 0, 0, 3);
        run_phase(R, 4, 1, 1, 0, 0, 4);

        // Non-one-hot samples.
        step(RG,   1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        step(RG,   1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        step(NONE, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0, 4);
        step(R,    1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        step(R,    1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 4);
        run_phase(G, 3, 2, 1, 0, 0, 4);

        // Asynchronous reset in the middle of a red phase.
        step(Y, 1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0, 4);
        step(R, 1'b0, 3'd1 == 3'd1 ? 1 : 1, 1'b1, 1'b0, 1'b0, 1'b1, 4);
        #3;
        rst_n = 1'b0;
        #1;
        chk_idle("async_rst");
        exp_fault = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("rst_hold");
        rst_n = 1'b1;
        run_phase(R, 3, 1, 0, 0, 0, 0);
        run_phase(G, 3, 2, 1, 0, 0, 0);
        run_phase(Y, 2, 3, 1, 0, 0, 0);
        run_phase(R, 4, 1, 1, 0, 0, 0);

        // Green of 2, 4 and 5 samples: tolerance-dependent expectations.
        run_phase(G, 2, 2, 1, 0, 0, 0);
        run_phase(Y, 2, 3, 1, (TOLB != 0) ? 0 : 1, 0, 0);
        run_phase(R, 4, 1, 1, 0, 0, TOLB);
        run_phase(G, 4, 2, 1, (TOLB != 0) ? 0 : 4, 0, TOLB);
        run_phase(Y, 2, 3, 1, 0, 0, TOLB);
        run_phase(R, 4, 1, 1, 0, 0, 2 * TOLB);
        run_phase(G, 5, 2, 1, (TOLB != 0) ? 5 : 4, 0, 2 * TOLB);
        run_phase(Y, 2, 3, 1, 0, 0, 2 * TOLB);
        run_phase(R, 2, 1, 1, 0, 0, 2 * TOLB);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/traffic_light_monitor.md
Name: traffic_light_monitor

Overview:
- Passive observer on the red/yellow/green outputs of traffic_light_controller: the receiving end of the light interface.
- Tracks the current phase and checks one-hot encoding, the legal order RED->GREEN->YELLOW->RED, and the duration of each phase in clock cycles.
- Raises per-cycle error pulses, a sticky fault flag and a completed-cycle count for the bench or a supervisor.
- Sits beside the controller on the same clk; it never drives the lights.

Parameters:
- RED_CYCLES, 4, required red phase length in clk cycles (>=1)
- GREEN_CYCLES, 3, required green phase length in clk cycles (>=1)
- YELLOW_CYCLES, 2, required yellow phase length in clk cycles (>=1)
- CNT_W, 8, phase counter width; every *_CYCLES value must be < 2^CNT_W-1
- TOL, 1, allowed +/- deviation in cycles; used only with TLM_TOLERANCE_EN

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- red  in  1  controller red light
- yellow  in  1  controller yellow light
- green  in  1  controller green light
- clear  in  1  clears fault (sync, 1 cycle)
- phase  out  2  0=unknown, 1=red, 2=green, 3=yellow
- locked  out  1  high while the phase sequence and timing are being checked
- err_onehot  out  1  1-cycle pulse: sampled lights not exactly one-hot
- err_order  out  1  1-cycle pulse: illegal phase transition
- err_timing  out  1  1-cycle pulse: phase overrun or underrun
- fault  out  1  sticky OR of all error pulses
- rounds  out  16  count of completed checked RED->GREEN->YELLOW->RED rounds; wraps at 0xFFFF->0

Behaviour:
- Reset (reset=0, async): phase=0, locked=0, all err_*=0, fault=0, rounds=0, counter=0, overrun=0, checked=0.
- Sampling: lights are sampled every rising edge. All outputs are registered and reflect the sample taken at that edge (1-cycle latency).
- States:
  - UNKNOWN (phase=0).
  - PARTIAL: phase known, duration not checked.
  - CHECKED: phase known, duration checked.
- Counter: reset to 1 on entering a phase, +1 per cycle in the same phase, saturating at all ones.
- Non-one-hot sample (000 or two or more lights high):
  - err_onehot=1.
  - Go to UNKNOWN; locked=0; counter=0.
  - Repeats every such cycle.
- From UNKNOWN, a valid one-hot sample enters that phase as PARTIAL.
- Same phase as before: counter increments.
  - If CHECKED and the counter reaches EXP+1 with overrun=0: err_timing=1 and overrun=1 (one pulse per phase).
- Legal transition out of PARTIAL: new phase is CHECKED, locked=1, no duration check on the phase just left.
- Legal transition out of CHECKED:
  - If overrun=0 and counter<EXP: err_timing=1 (underrun).
  - Leaving YELLOW for RED with no timing error during that round: rounds+1.
  - New phase is CHECKED; overrun cleared.
- Illegal transition (RED->YELLOW, GREEN->RED, YELLOW->GREEN):
  - err_order=1; locked=0.
  - New phase is PARTIAL; no timing check of the phase that ended.
- Exactly-EXP duration gives no error.
- Round qualification: a round counts only if its red phase was CHECKED.
- fault: set on any err_* pulse; cleared by clear=1. Set wins when clear and an error occur in the same cycle.
- Reset mid-phase abandons all tracking immediately. After reset release, the first phase is PARTIAL.

Optional Feature:
- TLM_TOLERANCE_EN defined: phase duration is accepted if it lies in [EXP-TOL, EXP+TOL].
  - Overrun fires at counter=EXP+TOL+1.
  - Underrun applies when counter < EXP-TOL, clamped at 1.
- Undefined: exact match is required and TOL is ignored.

Test Plan:
- Hold reset=0 mid-run with lights R=1 -> all outputs 0 asynchronously. After release, the first red is PARTIAL and locked=0 until the first legal transition.
- Clean loop R4 G3 Y2 repeated 3 rounds after lock -> no err_*, fault=0, locked=1 and phase tracking 1/2/3. rounds=2 (first red PARTIAL, so the first round does not count).
- G held 5 cycles in a locked loop -> err_timing pulses exactly once, at cycle 4 of green. No underrun at exit, fault=1, that round not counted.
- Y held 1 cycle, then R -> err_timing pulse on the R sample, fault=1. Then clear=1 with no error -> fault=0.
- R then Y directly -> err_order=1, locked=0, phase=3. Next legal Y->R -> locked=1 with no timing error.
- Sample R+G=11 for 2 cycles -> err_onehot high both cycles, phase=0, locked=0. With TLM_TOLERANCE_EN and TOL=1, G of 2 or 4 cycles gives no err_timing, while G of 5 cycles fires err_timing.
